// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types and constants for the digit-serial magnitude comparator.
// Holds the FSM state enum, one-hot result codes and the digit-count helper.
package seq_cmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    // Result flags are packed as {gt, eq, lt}.
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;

    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/seq_magnitude_comparator_digit_cmp.sv
// Combinational unsigned compare of one DIGIT-bit slice.
// gt and lt are both low when the slices are equal.
module digit_cmp #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             gt,
    output logic             lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Digit-serial MSB-first magnitude comparator, unsigned or two's-complement.
// Optional build macro SEQ_CMP_EARLY_EXIT_EN finishes at the first differing digit.
module seq_magnitude_comparator
    import seq_cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_gt_B,
    output logic             A_eq_B,
    output logic             A_lt_B
);

    localparam int N  = num_digits(WIDTH, DIGIT);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0]    CNT_LOAD  = CW'(N);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [WIDTH-1:0] SIGN_FLIP = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [2:0]       r_res;
    logic             r_decided;
    logic             r_dec_gt;

    logic             w_gt;
    logic             w_lt;
    logic             w_load;
    logic             w_finish;
    logic             w_last;
    logic             w_dec_any;
    logic             w_dec_gt;
    logic [2:0]       w_res;

    digit_cmp #(
        .DIGIT (DIGIT)
    ) u_digit_cmp (
        .a  (r_a[WIDTH-1 -: DIGIT]),
        .b  (r_b[WIDTH-1 -: DIGIT]),
        .gt (w_gt),
        .lt (w_lt)
    );

    assign w_last    = (r_cnt == CNT_ONE);
    // A decision recorded on an earlier digit overrides whatever the current digit says.
    assign w_dec_any = r_decided | w_gt | w_lt;
    assign w_dec_gt  = r_decided ? r_dec_gt : w_gt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = CMP;
                end
            end
            CMP: begin
`ifdef SEQ_CMP_EARLY_EXIT_EN
                if (w_last || w_gt || w_lt) begin
`else
                if (w_last) begin
`endif
                    w_finish     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_res = RES_EQ;
        if (w_dec_any) begin
            w_res = w_dec_gt ? RES_GT : RES_LT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_res     <= RES_NONE;
            r_decided <= 1'b0;
            r_dec_gt  <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                // Flipping the sign bit maps two's-complement onto offset binary,
                // so the serial compare itself is always unsigned.
                r_a       <= is_signed ? (A ^ SIGN_FLIP) : A;
                r_b       <= is_signed ? (B ^ SIGN_FLIP) : B;
                r_cnt     <= CNT_LOAD;
                r_busy    <= 1'b1;
                r_decided <= 1'b0;
                r_dec_gt  <= 1'b0;
            end else if (r_state == CMP) begin
                r_a   <= r_a << DIGIT;
                r_b   <= r_b << DIGIT;
                r_cnt <= r_cnt - CNT_ONE;
                if (!r_decided && (w_gt || w_lt)) begin
                    r_decided <= 1'b1;
                    r_dec_gt  <= w_gt;
                end
                if (w_finish) begin
                    r_busy <= 1'b0;
                    r_res  <= w_res;
                end
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign A_gt_B = r_res[2];
    assign A_eq_B = r_res[1];
    assign A_lt_B = r_res[0];

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench for seq_magnitude_comparator (WIDTH=16, DIGIT=4).
// Stimulus pushes expected flags and done cycle; a monitor checks each done pulse.
module tb_seq_magnitude_comparator;

    localparam logic [2:0] E_GT = 3'b100;
    localparam logic [2:0] E_EQ = 3'b010;
    localparam logic [2:0] E_LT = 3'b001;

`ifdef SEQ_CMP_EARLY_EXIT_EN
    localparam int EARLY = 1;
`else
    localparam int EARLY = 0;
`endif

    typedef struct {
        logic [2:0] flags;
        int         cyc;
        string      name;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic        A_gt_B;
    logic        A_eq_B;
    logic        A_lt_B;

    exp_t q[$];
    int   cyc;
    int   checks;
    int   errors;

    seq_magnitude_comparator #(
        .WIDTH (16),
        .DIGIT (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .A_gt_B    (A_gt_B),
        .A_eq_B    (A_eq_B),
        .A_lt_B    (A_lt_B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] flags_now();
        return {A_gt_B, A_eq_B, A_lt_B};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.name, "_flags"}, {5'd0, flags_now()}, {5'd0, e.flags});
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL %s_latency: got done at cycle %0d expected %0d", e.name, cyc, e.cyc);
                end
                $display("txn %s flags=%03b cycle=%0d", e.name, flags_now(), cyc);
            end
        end
    end

    // Returns just after edge 0 (the edge that samples start).
    task automatic issue(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input int lat, input logic [2:0] ef, input bit exp_done);
        exp_t e;
        @(posedge clk);
        #1;
        A = a;
        B = b;
        is_signed = s;
        start = 1'b1;
        if (exp_done) begin
            e.flags = ef;
            e.cyc   = cyc + 1 + lat;
            e.name  = name;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((busy || q.size() != 0) && n < 50);
        if (busy || q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy=%0b pending=%0d expected idle", name, busy, q.size());
            q.delete();
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        A         = '0;
        B         = '0;
        #3;
        check("reset_outputs", {3'd0, busy, done, flags_now()}, 8'h00);
        #19;
        rst_n = 1'b1;

        // 1: equal operands, busy for four cycles
        issue("eq_1234", 16'h1234, 16'h1234, 1'b0, 4, E_EQ, 1);
        for (int i = 1; i <= 3; i++) begin
            check("busy_during", {7'd0, busy}, 8'd1);
            @(posedge clk);
            #1;
        end
        check("busy_during", {7'd0, busy}, 8'd1);
        @(posedge clk);
        #1;
        check("busy_after", {7'd0, busy}, 8'd0);
        wait_idle("eq_1234");

        // 2: sign-mode dependence, decided at the first digit
        issue("gt_u8000", 16'h8000, 16'h7FFF, 1'b0, EARLY ? 1 : 4, E_GT, 1);
        wait_idle("gt_u8000");
        issue("lt_s8000", 16'h8000, 16'h7FFF, 1'b1, EARLY ? 1 : 4, E_LT, 1);
        wait_idle("lt_s8000");

        // 3: last-digit difference; signed -1 vs 0; boundary equal cases
        issue("gt_1235", 16'h1235, 16'h1234, 1'b0, 4, E_GT, 1);
        wait_idle("gt_1235");
        issue("lt_sm1", 16'hFFFF, 16'h0000, 1'b1, EARLY ? 1 : 4, E_LT, 1);
        wait_idle("lt_sm1");
        issue("eq_zero", 16'h0000, 16'h0000, 1'b0, 4, E_EQ, 1);
        wait_idle("eq_zero");
        issue("eq_ones", 16'hFFFF, 16'hFFFF, 1'b1, 4, E_EQ, 1);
        wait_idle("eq_ones");
        issue("gt_u_ffff", 16'hFFFF, 16'h0000, 1'b0, EARLY ? 1 : 4, E_GT, 1);
        wait_idle("gt_u_ffff");

        // 4: start while busy is ignored
        issue("lt_0001", 16'h0001, 16'h0002, 1'b0, 4, E_LT, 1);
        @(posedge clk);
        #1;
        check("busy_at_restart", {7'd0, busy}, 8'd1);
        A = 16'hFFFF;
        B = 16'h0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("lt_0001");
        repeat (6) @(posedge clk);

        // 5: reset mid-compare aborts with no done
        issue("abort", 16'h4000, 16'h3000, 1'b0, 4, E_GT, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {3'd0, busy, done, flags_now()}, 8'h00);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_abort_idle", {3'd0, busy, done, flags_now()}, 8'h00);
        issue("gt_00ff", 16'h00FF, 16'h00FE, 1'b0, 4, E_GT, 1);

        // 6: back-to-back start in the done cycle; previous flags hold
        repeat (4) @(posedge clk);
        #1;
        check("b2b_done_seen", {7'd0, done}, 8'd1);
        begin
            exp_t e;
            A = 16'h0003;
            B = 16'h0003;
            is_signed = 1'b0;
            start = 1'b1;
            e.flags = E_EQ;
            e.cyc   = cyc + 1 + 4;
            e.name  = "eq_b2b";
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", {7'd0, busy}, 8'd1);
        check("b2b_hold0", {5'd0, flags_now()}, {5'd0, E_GT});
        @(posedge clk);
        #1;
        check("b2b_hold1", {5'd0, flags_now()}, {5'd0, E_GT});
        wait_idle("eq_b2b");
        repeat (3) @(posedge clk);
        #1;
        check("final_flags_hold", {5'd0, flags_now()}, {5'd0, E_EQ});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
